// File: rtl/pc_gen.sv
// Fetch-stage program counter generator.
// Holds the current fetch PC and advances it under stall control and the
// fetch handshake. Execute-stage redirects have top priority. A direct-mapped
// BTB with 2-bit saturating counters predicts the next PC and is trained by
// resolved branches.
module pc_gen #(
    parameter int unsigned XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned STALL_W     = 5,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_in,
    input  logic               fetch_ready,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               upd_valid,
    input  logic [XLEN-1:0]    upd_pc,
    input  logic               upd_taken,
    input  logic [XLEN-1:0]    upd_target,
    output logic [XLEN-1:0]    pc_out,
    output logic               pc_valid,
    output logic               pred_taken,
    output logic [XLEN-1:0]    pred_target
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    // The reset state is the asserted rst itself; WARM is the first cycle
    // after release, where pc_valid rises while pc_out still shows RESET_PC.
    typedef enum logic [0:0] {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              r_pc_valid;
    logic              w_pc_valid_nxt;

    logic              r_btb_valid [BTB_ENTRIES];
    logic [TAG_W-1:0]  r_btb_tag   [BTB_ENTRIES];
    logic [XLEN-1:0]   r_btb_tgt   [BTB_ENTRIES];
    logic [1:0]        r_btb_ctr   [BTB_ENTRIES];

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic              w_lk_hit;
    logic [XLEN-1:0]   w_pc_inc;
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_up_hit;
    logic              w_accept;
    logic              w_unused;

    // Only stall bit 0 and word-aligned PC bits matter to this block.
    assign w_unused = ^{stall_in, upd_pc[1:0]};

    assign w_pc_inc = r_pc + XLEN'(4);
    assign w_accept = r_pc_valid & fetch_ready & ~stall_in[0];

    // BTB lookup for the current fetch PC (sees pre-update contents).
    always_comb begin
        w_lk_idx    = r_pc[IDX_W+1:2];
        w_lk_tag    = r_pc[XLEN-1:IDX_W+2];
        w_lk_hit    = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
        pred_taken  = w_lk_hit & r_btb_ctr[w_lk_idx][1];
        pred_target = w_lk_hit ? r_btb_tgt[w_lk_idx] : w_pc_inc;
    end

    // BTB training index/tag decode.
    always_comb begin
        w_up_idx = upd_pc[IDX_W+1:2];
        w_up_tag = upd_pc[XLEN-1:IDX_W+2];
        w_up_hit = r_btb_valid[w_up_idx] && (r_btb_tag[w_up_idx] == w_up_tag);
    end

    // State register plus PC / valid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_WARM;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_valid <= w_pc_valid_nxt;
        end
    end

    // Next-state and next-PC selection: redirect, then accept, then hold.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pc_valid_nxt = r_pc_valid;
        case (r_state)
            ST_WARM: begin
                w_pc_valid_nxt = 1'b1;
                w_state_nxt    = ST_RUN;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
            end
            ST_RUN: begin
                w_pc_valid_nxt = 1'b1;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end else if (w_accept) begin
                    w_pc_nxt = pred_taken ? pred_target : w_pc_inc;
                end
            end
            default: begin
                w_state_nxt    = ST_WARM;
                w_pc_valid_nxt = 1'b0;
            end
        endcase
    end

    // BTB training: counter update on hit, allocation on taken miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_tag[i]   <= '0;
                r_btb_tgt[i]   <= '0;
                r_btb_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    r_btb_tgt[w_up_idx] <= upd_target;
                    if (r_btb_ctr[w_up_idx] != 2'b11) begin
                        r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] + 2'b01;
                    end
                end else if (r_btb_ctr[w_up_idx] != 2'b00) begin
                    r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                r_btb_valid[w_up_idx] <= 1'b1;
                r_btb_tag[w_up_idx]   <= w_up_tag;
                r_btb_tgt[w_up_idx]   <= upd_target;
                r_btb_ctr[w_up_idx]   <= 2'b10;
            end
        end
    end

    assign pc_out   = r_pc;
    assign pc_valid = r_pc_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with RESET_PC=0x100 and a 16-entry BTB.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stall_in;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    int checks   = 0;
    int failures = 0;

    pc_gen #(
        .XLEN(32),
        .RESET_PC(32'h100),
        .STALL_W(5),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_in(stall_in),
        .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .pc_out(pc_out),
        .pc_valid(pc_valid),
        .pred_taken(pred_taken),
        .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Train one branch on the next edge.
    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        step();
        upd_valid  = 1'b0;
    endtask

    // Redirect on the next edge (applies regardless of stall).
    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%0b exp=0", pc_valid);
        end
        checks++;
        if (pc_out !== 32'h100) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=00000100", pc_out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (pc_valid !== 1'b1 || pc_out !== 32'h100) begin
            failures++;
            $display("FAIL warm got=%b/%h exp=1/00000100", pc_valid, pc_out);
        end
        step();
        checks++;
        if (pc_out !== 32'h104) begin
            failures++;
            $display("FAIL seq1 got=%h exp=00000104", pc_out);
        end
        step();
        checks++;
        if (pc_out !== 32'h108 || pc_valid !== 1'b1) begin
            failures++;
            $display("FAIL seq2 got=%b/%h exp=1/00000108", pc_valid, pc_out);
        end
    endtask

    task automatic test_stall();
        redirect_to(32'h10);
        checks++;
        if (pc_out !== 32'h10) begin
            failures++;
            $display("FAIL redirect_run got=%h exp=00000010", pc_out);
        end
        stall_in = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_out !== 32'h10 || pc_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%b/%h exp=1/00000010", i, pc_valid, pc_out);
            end
        end
        // Upper stall bits must not hold the PC.
        stall_in = 5'b11110;
        step();
        checks++;
        if (pc_out !== 32'h14) begin
            failures++;
            $display("FAIL stall_hi_bits got=%h exp=00000014", pc_out);
        end
        stall_in = 5'b00001;
        redirect_to(32'h80);
        checks++;
        if (pc_out !== 32'h80) begin
            failures++;
            $display("FAIL redirect_in_stall got=%h exp=00000080", pc_out);
        end
        stall_in    = 5'b0;
        fetch_ready = 1'b0;
        step();
        step();
        checks++;
        if (pc_out !== 32'h80) begin
            failures++;
            $display("FAIL not_ready_hold got=%h exp=00000080", pc_out);
        end
        fetch_ready = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h84) begin
            failures++;
            $display("FAIL ready_resume got=%h exp=00000084", pc_out);
        end
    endtask

    task automatic test_btb_train();
        stall_in = 5'b00001;
        train(32'h20, 1'b1, 32'h200);            // ctr=2
        redirect_to(32'h18);
        stall_in = 5'b0;
        step();                                   // 0x1C
        step();                                   // 0x20
        checks++;
        if (pc_out !== 32'h20 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            failures++;
            $display("FAIL pred_hit got=%h/%b/%h exp=00000020/1/00000200", pc_out, pred_taken, pred_target);
        end
        step();
        checks++;
        if (pc_out !== 32'h200) begin
            failures++;
            $display("FAIL taken_fetch got=%h exp=00000200", pc_out);
        end
        stall_in = 5'b00001;
        train(32'h20, 1'b0, 32'h0);              // ctr=1
        redirect_to(32'h20);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h200) begin
            failures++;
            $display("FAIL weak_nt got=%b/%h exp=0/00000200", pred_taken, pred_target);
        end
        train(32'h20, 1'b0, 32'h0);              // ctr=0
        train(32'h20, 1'b0, 32'h0);              // stays 0
        train(32'h20, 1'b1, 32'h200);            // ctr=1
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL sat_low got=%b exp=0", pred_taken);
        end
        stall_in = 5'b0;
        step();
        checks++;
        if (pc_out !== 32'h24) begin
            failures++;
            $display("FAIL nt_fetch got=%h exp=00000024", pc_out);
        end
        stall_in = 5'b00001;
        train(32'h20, 1'b1, 32'h240);            // ctr=2
        train(32'h20, 1'b1, 32'h240);            // ctr=3
        train(32'h20, 1'b1, 32'h240);            // stays 3
        train(32'h20, 1'b0, 32'h0);              // ctr=2
        redirect_to(32'h20);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
            failures++;
            $display("FAIL sat_high got=%b/%h exp=1/00000240", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        // Entry 8 holds 0x20 (taken). 0x420 shares the index with a different tag.
        redirect_to(32'h420);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h424) begin
            failures++;
            $display("FAIL alias_miss got=%b/%h exp=0/00000424", pred_taken, pred_target);
        end
        // Same-cycle update and lookup: pre-update contents before the edge.
        upd_valid  = 1'b1;
        upd_pc     = 32'h420;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_pre got=%b exp=0", pred_taken);
        end
        step();
        upd_valid = 1'b0;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            failures++;
            $display("FAIL alias_alloc got=%b/%h exp=1/00000300", pred_taken, pred_target);
        end
        redirect_to(32'h20);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h24) begin
            failures++;
            $display("FAIL alias_evict got=%b/%h exp=0/00000024", pred_taken, pred_target);
        end
        // Not-taken miss must not allocate.
        train(32'h60, 1'b0, 32'h900);
        redirect_to(32'h60);
        checks++;
        if (pred_target !== 32'h64) begin
            failures++;
            $display("FAIL nt_no_alloc got=%h exp=00000064", pred_target);
        end
    endtask

    task automatic test_back_to_back();
        redirect_to(32'h420);                     // predicted taken to 0x300
        stall_in = 5'b0;
        redirect_to(32'h40);
        checks++;
        if (pc_out !== 32'h40) begin
            failures++;
            $display("FAIL redirect_priority got=%h exp=00000040", pc_out);
        end
        redirect_to(32'hFFFF_FFFC);
        checks++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_setup got=%h exp=fffffffc", pc_out);
        end
        step();
        checks++;
        if (pc_out !== 32'h0) begin
            failures++;
            $display("FAIL wrap got=%h exp=00000000", pc_out);
        end
        step();
        step();
        checks++;
        if (pc_out !== 32'h8) begin
            failures++;
            $display("FAIL throughput got=%h exp=00000008", pc_out);
        end
    endtask

    task automatic test_reset_midrun();
        stall_in = 5'b0;
        redirect_to(32'h500);
        rst = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h100 || pc_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%b/%h exp=0/00000100", pc_valid, pc_out);
        end
        step();
        stall_in = 5'b00001;
        rst = 1'b1;
        step();
        checks++;
        if (pc_valid !== 1'b1 || pc_out !== 32'h100) begin
            failures++;
            $display("FAIL rewarm got=%b/%h exp=1/00000100", pc_valid, pc_out);
        end
        redirect_to(32'h420);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h424) begin
            failures++;
            $display("FAIL btb_cleared got=%b/%h exp=0/00000424", pred_taken, pred_target);
        end
        // One taken update after reset allocates with ctr=2 (counters reset to 1).
        train(32'h420, 1'b1, 32'h700);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h700) begin
            failures++;
            $display("FAIL post_reset_alloc got=%b/%h exp=1/00000700", pred_taken, pred_target);
        end
    endtask

    initial begin
        rst            = 1'b0;
        stall_in       = '0;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        #1;
        test_reset();
        test_stall();
        test_btb_train();
        test_alias();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, the next generation of the single-cycle PC register. It holds the current fetch PC, advances it under stall control and an instruction-fetch handshake, and accepts redirects from the execute stage. A direct-mapped branch target buffer with 2-bit saturating counters predicts the next PC, and is trained by resolved branches.

## Interface
- XLEN, 32, PC / target width in bits
- RESET_PC, 32'h0, PC presented after reset
- STALL_W, 5, width of stall vector; only bit 0 affects this block
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- clk  in  1  sole clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- stall_in  in  STALL_W  bit 0 high = hold PC
- fetch_ready  in  1  fetch unit accepts pc_out this cycle
- redirect_valid  in  1  execute-stage redirect (mispredict / jump)
- redirect_pc  in  XLEN  redirect target
- upd_valid  in  1  resolved branch training strobe
- upd_pc  in  XLEN  PC of resolved branch
- upd_taken  in  1  resolved direction
- upd_target  in  XLEN  resolved target
- pc_out  out  XLEN  current fetch PC (registered)
- pc_valid  out  1  pc_out is a valid fetch request (registered)
- pred_taken  out  1  BTB predicts pc_out taken (combinational from pc_out)
- pred_target  out  XLEN  predicted target for pc_out (combinational)

## Operation
- States: RESET (rst low), WARM (first cycle after release), RUN.
- RESET: pc_out=RESET_PC, pc_valid=0, all BTB valid bits 0, all counters 2'b01; applies immediately on rst falling, mid-operation included.
- WARM: at first rising edge with rst high, pc_valid<=1, pc_out stays RESET_PC; go to RUN. Redirect in this cycle still applies (pc_out<=redirect_pc).
- Accept = pc_valid & fetch_ready & ~stall_in[0].
- Next-PC priority, RUN: (1) redirect_valid: pc_out<=redirect_pc, regardless of stall/ready; (2) accept: pc_out<=pred_taken ? pred_target : pc_out+4; (3) otherwise hold.
- pc_valid stays 1 in RUN; never drops except in reset.
- PC arithmetic modulo 2^XLEN: pc_out+4 wraps to 0 from 2^XLEN-4.
- BTB entry: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], ctr[2]; index = pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup: hit = valid & tag match at index(pc_out); pred_taken = hit & ctr[1]; pred_target = entry target when hit, else pc_out+4.
- Training on upd_valid:
  - hit: ctr increments (saturating at 3) if taken, decrements (saturating at 0) if not; target overwritten only if taken.
  - miss & taken: allocate/replace: valid=1, tag, target=upd_target, ctr=2'b10.
  - miss & not taken: no change.
- Same-cycle update and lookup of the same entry: lookup sees pre-update contents; new contents are visible from next cycle.
- The block does not track whether a prediction was correct; execute issues redirect_valid on mispredict.

## Timing
- pc_out/pc_valid change only on clk rising edge or asynchronous rst assertion.
- Redirect latency 1 cycle: redirect_valid at edge N -> pc_out=redirect_pc after N.
- Sequential throughput: one PC per cycle while accept holds.
- Predicted-taken fetch: no bubble; target appears the cycle after accept.
- Training latency: update at edge N affects pred_taken from after N.
- stall_in[0] or ~fetch_ready: pc_out held indefinitely, no BTB side effect.

## Test plan
- Reset release with RESET_PC=32'h100, fetch_ready=1, no stall -> pc_valid=0 during reset; cycle 1 pc_out=0x100 valid; then 0x104, 0x108.
- stall_in[0]=1 for 3 cycles at pc_out=0x10 -> held at 0x10; redirect_valid with redirect_pc=0x80 during stall -> 0x80 next cycle.
- Train upd_pc=0x20, taken, target 0x200 once -> ctr=2; fetch reaching 0x20 gives pred_taken=1, next pc_out=0x200; two not-taken updates -> ctr=0, 0x20 followed by 0x24.
- Aliasing, BTB_ENTRIES=16: train 0x20 taken; lookup 0x420 (same index, different tag) -> pred_taken=0; train 0x420 taken -> 0x20 now misses.
- Simultaneous redirect and predicted-taken accept -> redirect_pc wins; pc_out=0xFFFFFFFC sequential accept -> wraps to 0.
- Assert rst mid-run after training -> pc_out=RESET_PC and pc_valid=0 immediately; after release all BTB entries miss.
